// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory sequencer: FSM states, address-space
// select bit and the instruction fields the sequencer inspects.
package hack_pkg;

  typedef enum logic [2:0] {
    S_IFETCH = 3'd0,
    S_IWAIT  = 3'd1,
    S_DWAIT  = 3'd2,
    S_EXEC   = 3'd3,
    S_VWAIT  = 3'd4
  } state_t;

  localparam int INST_SPACE_BIT = 15;
  localparam int INST_C_BIT     = 15;
  localparam int INST_A_BIT     = 12;
  localparam int INST_DST_M_BIT = 3;

  // A C-instruction with a=1 takes its ALU operand from M, so it needs the data read.
  function automatic logic uses_m(input logic [15:0] inst);
    return inst[INST_C_BIT] & inst[INST_A_BIT];
  endfunction

endpackage

// File: rtl/hack_mem_sequencer_if.sv
// Bus bundle between the sequencer (master) and the CPU core, video scanner
// and RAM macro around it (slave).
interface hack_mem_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-2:0] cpu_inst_addr;
  logic [ADDR_W-2:0] cpu_data_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_ce;
  logic [DATA_W-1:0] cpu_inst;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-2:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_inst_addr, cpu_data_addr, cpu_wdata, cpu_we,
    output cpu_ce, cpu_inst, cpu_rdata,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cpu_inst_addr, cpu_data_addr, cpu_wdata, cpu_we,
    input  cpu_ce, cpu_inst, cpu_rdata,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/hack_mem_sequencer.sv
// Time-shares one single-port RAM between Hack CPU fetch/read/write and video scan-out.
// Build option HACK_SKIP_DREAD_EN: skip the data read for instructions that do not use M.
module hack_mem_sequencer
  import hack_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  hack_mem_sequencer_if.master bus
);

  state_t            state;
  state_t            state_nx;
  logic              vid_served;
  logic              vid_served_nx;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] rdata_q;

  logic              inst_ld;
  logic              rdata_ld;
  logic              en_c;
  logic              we_c;
  logic              ce_c;
  logic              gnt_c;
  logic              rvalid_c;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    state_nx      = state;
    vid_served_nx = vid_served;
    inst_ld       = 1'b0;
    rdata_ld      = 1'b0;
    en_c          = 1'b0;
    we_c          = 1'b0;
    ce_c          = 1'b0;
    gnt_c         = 1'b0;
    rvalid_c      = 1'b0;
    addr_c        = '0;
    addr_c[ADDR_W-2:0] = bus.cpu_data_addr;

    case (state)
      S_IFETCH: begin
        en_c = 1'b1;
        // One video slot per instruction, taken ahead of the fetch.
        if (bus.vid_req && !vid_served) begin
          addr_c[ADDR_W-2:0] = bus.vid_addr;
          gnt_c              = 1'b1;
          state_nx           = S_VWAIT;
        end else begin
          addr_c[ADDR_W-2:0]     = bus.cpu_inst_addr;
          addr_c[INST_SPACE_BIT] = 1'b1;
          state_nx               = S_IWAIT;
        end
      end

      S_VWAIT: begin
        rvalid_c      = 1'b1;
        vid_served_nx = 1'b1;
        state_nx      = S_IFETCH;
      end

      S_IWAIT: begin
        inst_ld = 1'b1;
`ifdef HACK_SKIP_DREAD_EN
        if (uses_m(bus.mem_rdata)) begin
          en_c     = 1'b1;
          state_nx = S_DWAIT;
        end else begin
          state_nx = S_EXEC;
        end
`else
        en_c     = 1'b1;
        state_nx = S_DWAIT;
`endif
      end

      S_DWAIT: begin
        rdata_ld = 1'b1;
        state_nx = S_EXEC;
      end

      S_EXEC: begin
        ce_c          = 1'b1;
        en_c          = bus.cpu_we;
        we_c          = bus.cpu_we;
        vid_served_nx = 1'b0;
        state_nx      = S_IFETCH;
      end

      default: state_nx = S_IFETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IFETCH;
      vid_served <= 1'b0;
      inst_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nx;
      vid_served <= vid_served_nx;
      if (inst_ld)  inst_q  <= bus.mem_rdata;
      if (rdata_ld) rdata_q <= bus.mem_rdata;
    end
  end

  // Strobes are masked in the reset cycle so an aborted exec never writes.
  assign bus.mem_en     = en_c & nrst;
  assign bus.mem_we     = we_c & nrst;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wdata  = bus.cpu_wdata;
  assign bus.cpu_ce     = ce_c & nrst;
  assign bus.cpu_inst   = inst_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.vid_gnt    = gnt_c & nrst;
  assign bus.vid_rvalid = rvalid_c & nrst;
  assign bus.vid_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_hack_mem_sequencer.sv
// Bench for hack_mem_sequencer: RAM model, per-instruction slot-plan reference model,
// directed scenarios with literal expectations, then randomized CPU/video/reset traffic.
module tb_hack_mem_sequencer;

`ifdef HACK_SKIP_DREAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int OP_VGNT   = 0;
  localparam int OP_VRD    = 1;
  localparam int OP_FETCH  = 2;
  localparam int OP_DREAD  = 3;
  localparam int OP_DLATCH = 4;
  localparam int OP_EXEC   = 5;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  hack_mem_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  hack_mem_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Power-on RAM contents: directed program words plus a hash elsewhere.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h8000: return 16'h0005;
      16'h8001: return 16'hEC10;
      16'h8002: return 16'hE308;
      16'h8003: return 16'hFC10;
      16'h8004: return 16'hFC10;
      16'h8005: return 16'hFC10;
      16'h8006: return 16'hFC10;
      16'h8007: return 16'h0003;
      16'h8008: return 16'hEC10;
      16'h0007: return 16'h1234;
      16'h4000: return 16'hBEEF;
      default:  return (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  // RAM macro: one-cycle read latency, write at the edge.
  logic [15:0] ram    [0:65535];
  bit          ram_wr [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr]    <= bus.mem_wdata;
      ram_wr[bus.mem_addr] <= 1'b1;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
    end
  end

  // Reference model: expected memory image plus the ordered slot plan of one instruction.
  logic [15:0] shadow [0:65535];
  bit          sh_wr  [0:65535];
  int          plan[$];
  int          op;
  logic [15:0] exp_inst, exp_rdata, cur_inst, cur_data;
  logic [14:0] cur_vaddr;

  function automatic logic [15:0] sh_rd(input logic [15:0] a);
    return sh_wr[a] ? shadow[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (!nrst) begin
      chk1("rst_cpu_ce", bus.cpu_ce, 1'b0);
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk1("rst_vid_gnt", bus.vid_gnt, 1'b0);
      chk1("rst_vid_rvalid", bus.vid_rvalid, 1'b0);
      plan.delete();
      exp_inst  = 16'h0000;
      exp_rdata = 16'h0000;
    end else begin
      if (plan.size() == 0) begin
        if (bus.vid_req) begin
          plan.push_back(OP_VGNT);
          plan.push_back(OP_VRD);
        end
        plan.push_back(OP_FETCH);
        plan.push_back(OP_DREAD);
        plan.push_back(OP_DLATCH);
        plan.push_back(OP_EXEC);
      end
      op = plan.pop_front();
      chk16("cpu_inst", bus.cpu_inst, exp_inst);
      chk16("cpu_rdata", bus.cpu_rdata, exp_rdata);
      chk1("cpu_ce", bus.cpu_ce, op == OP_EXEC);
      chk1("vid_gnt", bus.vid_gnt, op == OP_VGNT);
      chk1("vid_rvalid", bus.vid_rvalid, op == OP_VRD);
      if (op != OP_EXEC) chk1("mem_we", bus.mem_we, 1'b0);
      case (op)
        OP_VGNT: begin
          chk1("vgnt_mem_en", bus.mem_en, 1'b1);
          chk16("vgnt_mem_addr", bus.mem_addr, {1'b0, bus.vid_addr});
          cur_vaddr = bus.vid_addr;
        end
        OP_VRD: begin
          chk1("vrd_mem_en", bus.mem_en, 1'b0);
          chk16("vid_rdata", bus.vid_rdata, sh_rd({1'b0, cur_vaddr}));
        end
        OP_FETCH: begin
          chk1("fetch_mem_en", bus.mem_en, 1'b1);
          chk16("fetch_mem_addr", bus.mem_addr, {1'b1, bus.cpu_inst_addr});
          cur_inst = sh_rd({1'b1, bus.cpu_inst_addr});
        end
        OP_DREAD: begin
          if (SKIP && !(cur_inst[15] && cur_inst[12])) begin
            chk1("skip_mem_en", bus.mem_en, 1'b0);
            void'(plan.pop_front());
          end else begin
            chk1("dread_mem_en", bus.mem_en, 1'b1);
            chk16("dread_mem_addr", bus.mem_addr, {1'b0, bus.cpu_data_addr});
            cur_data = sh_rd({1'b0, bus.cpu_data_addr});
          end
          exp_inst = cur_inst;
        end
        OP_DLATCH: begin
          chk1("dlatch_mem_en", bus.mem_en, 1'b0);
          exp_rdata = cur_data;
        end
        default: begin
          chk1("exec_mem_en", bus.mem_en, bus.cpu_we);
          chk1("exec_mem_we", bus.mem_we, bus.cpu_we);
          if (bus.cpu_we) begin
            chk16("exec_mem_addr", bus.mem_addr, {1'b0, bus.cpu_data_addr});
            chk16("exec_mem_wdata", bus.mem_wdata, bus.cpu_wdata);
            shadow[{1'b0, bus.cpu_data_addr}] = bus.cpu_wdata;
            sh_wr[{1'b0, bus.cpu_data_addr}]  = 1'b1;
          end
        end
      endcase
    end
  end

  // Observations of one instruction, collected by run_inst.
  int          ncyc, ngnt, gnt_at, rv_at, nwe;
  logic [15:0] rv_data, ce_inst, ce_rdata, ce_addr, ce_wdata, first_inst, first_rdata, rd_before;
  logic [15:0] a1, a2;
  logic        e1, e2, ce_we;

  task automatic run_inst(input logic [14:0] pc, input logic [14:0] a,
                          input logic [15:0] wd, input logic w);
    bit done;
    bus.cpu_inst_addr = pc;
    bus.cpu_data_addr = a;
    bus.cpu_wdata     = wd;
    bus.cpu_we        = w;
    ncyc = 0; ngnt = 0; gnt_at = 0; rv_at = 0; nwe = 0; done = 1'b0;
    rd_before = bus.cpu_rdata;
    while (!done && ncyc < 12) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) begin
        a1 = bus.mem_addr; e1 = bus.mem_en;
        first_inst = bus.cpu_inst; first_rdata = bus.cpu_rdata;
      end
      if (ncyc == 2) begin a2 = bus.mem_addr; e2 = bus.mem_en; end
      if (bus.vid_gnt) begin ngnt++; gnt_at = ncyc; end
      if (bus.vid_rvalid) begin rv_at = ncyc; rv_data = bus.vid_rdata; end
      if (bus.mem_we) nwe++;
      if (bus.cpu_ce) begin
        done     = 1'b1;
        ce_inst  = bus.cpu_inst;
        ce_rdata = bus.cpu_rdata;
        ce_addr  = bus.mem_addr;
        ce_wdata = bus.mem_wdata;
        ce_we    = bus.mem_we;
      end
    end
    chk1("cpu_ce_within_budget", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  logic rst_we, rst_ce, ce_prev, g_prev, rst_prev;

  initial begin
    bus.cpu_inst_addr = '0;
    bus.cpu_data_addr = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_we        = 1'b0;
    bus.vid_req       = 1'b0;
    bus.vid_addr      = '0;
    bus.mem_rdata     = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // First instruction after reset: @5 at 0x8000
    run_inst(15'd0, 15'd0, 16'h0000, 1'b0);
    chk16("t1_fetch_addr", a1, 16'h8000);
    chk1("t1_fetch_en", e1, 1'b1);
    chk16("t1_dread_addr", a2, 16'h0000);
    chk1("t1_dread_en", e2, 1'b1);
    chkint("t1_cycles", ncyc, 4);
    chk16("t1_inst_reset_value", first_inst, 16'h0000);
    chk16("t1_inst", ce_inst, 16'h0005);

    // D=A then M=D with A=5
    run_inst(15'd1, 15'd5, 16'h0000, 1'b0);
    chk16("t2_inst_dA", ce_inst, 16'hEC10);
    run_inst(15'd2, 15'd5, 16'h0005, 1'b1);
    chk1("t2_exec_we", ce_we, 1'b1);
    chk16("t2_exec_addr", ce_addr, 16'h0005);
    chk16("t2_exec_wdata", ce_wdata, 16'h0005);
    run_inst(15'd4, 15'd5, 16'h0000, 1'b0);
    chk16("t2_readback", ce_rdata, 16'h0005);

    // D=M with A=7
    run_inst(15'd3, 15'd7, 16'h0000, 1'b0);
    chk16("t3_rdata", ce_rdata, 16'h1234);

    // Video held at 0x4000 across two instructions
    bus.vid_req  = 1'b1;
    bus.vid_addr = 15'h4000;
    for (int k = 0; k < 2; k++) begin
      run_inst(15'(5 + k), 15'd7, 16'h0000, 1'b0);
      chkint("t4_period", ncyc, 6);
      chkint("t4_gnt_count", ngnt, 1);
      chkint("t4_rvalid_delay", rv_at - gnt_at, 1);
      chk16("t4_vid_rdata", rv_data, 16'hBEEF);
    end
    bus.vid_req = 1'b0;

    // Reset during the data-read wait of an M=D instruction
    bus.cpu_inst_addr = 15'd2;
    bus.cpu_data_addr = 15'd9;
    bus.cpu_wdata     = 16'h0077;
    bus.cpu_we        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    rst_we = bus.mem_we;
    rst_ce = bus.cpu_ce;
    @(posedge clk);
    #1 nrst = 1'b1;
    chk1("t5_no_write", rst_we, 1'b0);
    chk1("t5_no_ce", rst_ce, 1'b0);
    run_inst(15'd0, 15'd9, 16'h0000, 1'b0);
    chk16("t5_fetch_addr", a1, 16'h8000);
    chk16("t5_inst_reset_value", first_inst, 16'h0000);
    chk16("t5_rdata_reset_value", first_rdata, 16'h0000);
    chkint("t5_no_we_after", nwe, 0);

    // A-instruction then D=A: no M operand
    for (int k = 0; k < 2; k++) begin
      run_inst(15'(7 + k), 15'h11, 16'h0000, 1'b0);
`ifdef HACK_SKIP_DREAD_EN
      chkint("t6_cycles", ncyc, 3);
      chk1("t6_iwait_en", e2, 1'b0);
      chk16("t6_rdata_held", ce_rdata, rd_before);
`else
      chkint("t6_cycles", ncyc, 4);
      chk1("t6_iwait_en", e2, 1'b1);
      chk16("t6_rdata", ce_rdata, init_val(16'h0011));
`endif
    end

    // Randomized CPU, video and reset traffic
    ce_prev = 1'b1; g_prev = 1'b0; rst_prev = 1'b0;
    repeat (3000) begin
      if (!nrst) nrst = 1'b1;
      else if ($urandom_range(0, 199) == 0) nrst = 1'b0;
      if (ce_prev || rst_prev) begin
        bus.cpu_inst_addr = 15'(16 + $urandom_range(0, 63));
        bus.cpu_data_addr = 15'(16 + $urandom_range(0, 63));
        bus.cpu_wdata     = 16'($urandom);
        bus.cpu_we        = 1'($urandom_range(0, 1));
      end
      if (g_prev) bus.vid_req = 1'b0;
      else if (!bus.vid_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.vid_req  = 1'b1;
          bus.vid_addr = 15'(16 + $urandom_range(0, 63));
        end
      end else if ($urandom_range(0, 15) == 0) bus.vid_req = 1'b0;
      @(negedge clk);
      ce_prev  = bus.cpu_ce;
      g_prev   = bus.vid_gnt;
      rst_prev = !nrst;
      @(posedge clk);
      #1;
    end
    nrst = 1'b1;
    bus.vid_req = 1'b0;
    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_mem_sequencer.md
Name: hack_mem_sequencer

Overview:
- Sequences the single-cycle Hack CPU core onto one shared single-port synchronous RAM that holds both instruction and data space.
- Also time-shares that RAM with a video scan-out requester.
- The block performs the instruction fetch and the data read, then pulses a CPU clock-enable for exactly one execute cycle, during which any data write is committed.
- Sits between the CPU core, the video scanner and the RAM macro in the top level.

Parameters:
- ADDR_W, 16, RAM address width. Bit 15 = 1 selects instruction space, bit 15 = 0 selects data space.
- DATA_W, 16, word width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset (see Behaviour)
- cpu_inst_addr  in  15  CPU pc
- cpu_data_addr  in  15  CPU A[14:0]
- cpu_wdata  in  16  CPU alu output
- cpu_we  in  1  CPU write request (valid only with held inst)
- cpu_ce  out  1  CPU register-update enable. All pc/A/D updates except reset are gated by it.
- cpu_inst  out  16  latched instruction to CPU
- cpu_rdata  out  16  latched data word to CPU (inM)
- vid_req  in  1  video read request, level, held until granted
- vid_addr  in  15  video data-space word address
- vid_gnt  out  1  pulse: request accepted this cycle
- vid_rvalid  out  1  pulse: vid_rdata valid
- vid_rdata  out  16  video read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write
- mem_addr  out  16  RAM address
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data; valid the cycle after the access is issued

Behaviour:
- Reset: nrst is synchronous, active-low; clock clk.
- Reset values: state = S_IFETCH, inst_q = 0, rdata_q = 0, all strobes 0 (cpu_ce, mem_en, mem_we, vid_gnt, vid_rvalid).
- RAM model: 1-cycle read latency, no wait states. Write takes effect at the edge.
- S_IFETCH, video slot check:
  - If vid_req = 1 and vid_served = 0: mem_en = 1, mem_addr = {0, vid_addr}, vid_gnt = 1, then go to S_VWAIT.
  - Otherwise: mem_en = 1, mem_addr = {1, cpu_inst_addr}, then go to S_IWAIT.
- S_VWAIT:
  - vid_rdata = mem_rdata, vid_rvalid = 1, set vid_served.
  - Then S_IFETCH, which now issues the fetch.
- S_IWAIT:
  - inst_q <= mem_rdata.
  - Same cycle: mem_en = 1, mem_addr = {0, cpu_data_addr}. A is stable because cpu_ce = 0.
  - Then S_DWAIT.
- S_DWAIT: rdata_q <= mem_rdata, then S_EXEC.
- S_EXEC:
  - cpu_ce = 1.
  - If cpu_we = 1: mem_en = 1, mem_we = 1, mem_addr = {0, cpu_data_addr}, mem_wdata = cpu_wdata.
  - Clear vid_served, then S_IFETCH.
- Throughput:
  - 4 cycles per instruction.
  - At most one video access per instruction, adding 2 cycles. Video worst-case grant latency is 6 cycles.
- cpu_inst and cpu_rdata are driven from inst_q and rdata_q at all times and change only in S_IWAIT and S_DWAIT.
- cpu_ce = 1 in S_EXEC only, never outside it.
- Write-then-fetch: a write in S_EXEC is visible to the next fetch or data read. The RAM provides write-before-read ordering across cycles.
- vid_req dropped before vid_gnt: no access issued. vid_req asserted in S_EXEC: considered at the next S_IFETCH.
- Reset mid-operation: abort immediately, return to S_IFETCH, no write issued in the reset cycle, vid_served = 0.
- A pending video request is lost; the requester must re-request.

Optional Feature:
- Macro: HACK_SKIP_DREAD_EN.
- Defined: in S_IWAIT, if mem_rdata[15] = 0 or mem_rdata[12] = 0 (M not used), no data read is issued (mem_en = 0) and the FSM goes directly to S_EXEC. rdata_q holds its old value. Such instructions take 3 cycles.
- Undefined: the data read is always issued; 4 cycles per instruction.

Decomposition:
- Shared package hack_pkg:
  - state enum (S_IFETCH, S_IWAIT, S_DWAIT, S_EXEC, S_VWAIT);
  - INST_SPACE_BIT = 15;
  - instruction field constants INST_C_BIT = 15, INST_A_BIT = 12, INST_DST_M_BIT = 3.
- Single module, no sub-module. The FSM plus output muxing is small enough to keep flat.

Test Plan:
- Reset, then release with RAM[0x8000] = 0x0005 (@5):
  - mem_addr = 0x8000 in cycle 1, then 0x0000 in cycle 2;
  - cpu_ce pulses in cycle 4;
  - cpu_inst = 0x0005.
- Instruction 0xEC10 (D=A), then 0xE308 (M=D) with A = 5:
  - the exec cycle of the second instruction shows mem_we = 1, mem_addr = 0x0005, mem_wdata = 5;
  - the next data read of address 5 returns 5.
- Instruction 0xFC10 (D=M) with RAM[7] = 0x1234 and A = 7: cpu_rdata = 0x1234 at cpu_ce.
- vid_req held with vid_addr = 0x4000 during a run:
  - exactly one vid_gnt per instruction;
  - vid_rvalid is 1 cycle after vid_gnt, with vid_rdata = RAM[0x4000];
  - the CPU period is 6 cycles.
- nrst asserted in S_DWAIT of an M=D instruction:
  - no mem_we;
  - state is S_IFETCH, outputs at reset values;
  - the next fetch is at address 0x8000.
- With HACK_SKIP_DREAD_EN, instructions @3 then 0xEC10:
  - 3 cycles per instruction;
  - mem_en = 0 in S_IWAIT;
  - rdata_q unchanged.
